// File: rtl/ram_fifo_ctrl.sv
// Byte FIFO controller for a single-port register RAM.
// Pop has priority over push; output byte is registered.
module ram_fifo_ctrl #(
  parameter int DEPTH     = 48,
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_BITS-1:0] count,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_wdata,
  input  logic [DATA_BITS-1:0] ram_rdata
);

  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] FULL = ADDR_BITS'(DEPTH);

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 pop_want;
  logic                 push;

  function automatic logic [ADDR_BITS-1:0] nxt(
    input logic [ADDR_BITS-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign pop_want = (count != '0) &&
                    (!out_valid || out_ready);
  assign in_ready = !rst && (count != FULL) &&
                    !pop_want;
  assign push     = in_valid && in_ready;

  // RAM port steering: write back read data unless pushing
  always_comb begin
    ram_addr  = rd_ptr;
    ram_wdata = ram_rdata;
    unique case (1'b1)
      rst: begin
        ram_addr = '0;
      end
      pop_want: begin
        ram_addr = rd_ptr;
      end
      push: begin
        ram_addr  = wr_ptr;
        ram_wdata = in_data;
      end
      default: begin
        ram_addr = rd_ptr;
      end
    endcase
  end

  // Pointers, occupancy and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop_want) begin
      out_data  <= ram_rdata;
      out_valid <= 1'b1;
      rd_ptr    <= nxt(rd_ptr);
      count     <= count - 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= nxt(wr_ptr);
        count  <= count + 1'b1;
      end
      if (out_valid && out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: RAM model, scoreboard
// monitor and directed plus randomized stimulus.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] count;
  logic [5:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  logic [7:0] mem [48];
  logic [7:0] q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_out    = 0;
  int wraps    = 0;

  ram_fifo_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // 48-byte RAM: write every edge, combinational read
  assign ram_rdata = (ram_addr < 6'd48) ? mem[ram_addr] : 8'h00;
  always @(posedge clk)
    if (ram_addr < 6'd48) mem[ram_addr] <= ram_wdata;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: decide each cycle's transfers mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      n_push = 0;
      check("rst_wdata_hold", ram_wdata, ram_rdata);
    end else begin
      check("addr_range", 32'(ram_addr < 6'd48), 1);
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0)
          check("sb_underflow", 0, 1);
        else
          check("sb_data", out_data, q.pop_front());
      end
      if (in_valid && in_ready) begin
        check("push_addr", ram_addr, n_push % 48);
        check("push_wdata", ram_wdata, in_data);
        if (ram_addr == 6'd0 && n_push > 0) wraps++;
        n_push++;
        q.push_back(in_data);
      end else begin
        check("ram_preserve", ram_wdata, ram_rdata);
      end
      if (count != 0 && (!out_valid || out_ready))
        check("pop_prio_in_ready", in_ready, 0);
      if (count == 0)
        check("empty_in_ready", in_ready, 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a byte until accepted or maxc cycles pass
  task automatic offer(input logic [7:0] b, input int maxc,
                       output bit ok);
    bit acc;
    ok = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit ok;
    offer(b, 200, ok);
    in_valid = 1'b0;
    check("push_timeout", 32'(ok), 1);
  endtask

  task automatic wait_drain(input int maxc);
    bit done;
    done = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (!out_valid && count == 0) begin
        done = 1;
        break;
      end
      step();
    end
    if (done) step();
    check("drain_timeout", 32'(done), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    int base;
    int w0;
    int i;
    int cyc;
    for (int k = 0; k < 48; k++) mem[k] = 8'($urandom);
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;

    // Reset
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_count", count, 0);
      check("rst_wdata", ram_wdata, ram_rdata);
      check("rst_in_ready", in_ready, 0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    step();

    // Order
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    @(negedge clk);
    check("order_out_valid", out_valid, 1);
    check("order_out_data", out_data, 8'h11);
    check("order_count", count, 2);
    step();
    base = n_out;
    out_ready = 1'b1;
    wait_drain(50);
    check("order_n_out", n_out - base, 3);

    // Full
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 50; k++) begin
      offer(8'(k), 10, ok);
      if (ok) acc++;
    end
    @(negedge clk);
    check("full_accepted", acc, 49);
    check("full_count", count, 48);
    check("full_in_ready", in_ready, 0);
    check("full_out_data", out_data, 8'h00);
    check("full_in_data_held", in_data, 8'h31);
    step();
    base = n_out;
    out_ready = 1'b1;
    offer(8'h31, 200, ok);
    in_valid = 1'b0;
    check("full_last_accepted", 32'(ok), 1);
    wait_drain(300);
    check("full_n_out", n_out - base, 50);

    // Wrap: random valid/ready
    base = n_out;
    w0 = wraps;
    i = 0;
    cyc = 0;
    while (i < 200 && cyc < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'(i);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ok = in_valid && in_ready;
      step();
      if (ok) i++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("wrap_pushed", i, 200);
    wait_drain(1000);
    check("wrap_n_out", n_out - base, 200);
    check("wrap_ptr_wraps", 32'(wraps - w0 >= 4), 1);

    // Contention and reset mid-stream
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) push_byte(8'h40 + 8'(k));
    @(negedge clk);
    check("mid_count", count, 5);
    check("mid_out_valid", out_valid, 1);
    step();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h77;
    @(negedge clk);
    check("contend_in_ready", in_ready, 0);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_count", count, 0);
    check("mid_rst_out_valid", out_valid, 0);
    step();
    out_ready = 1'b1;
    push_byte(8'hA5);
    @(negedge clk);
    check("lat_n1_out_valid", out_valid, 0);
    step();
    @(negedge clk);
    check("lat_n2_out_valid", out_valid, 1);
    check("lat_n2_out_data", out_data, 8'hA5);
    step();
    wait_drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
